// File: rtl/lr35902_pkg.sv
// rtl/lr35902_pkg.sv - shared LR35902 definitions used by the OAM DMA engine
package lr35902_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } oam_dma_state_e;

    localparam logic [7:0] OAM_DMA_REG_ADR = 8'h46;
    localparam int unsigned OAM_DMA_LEN    = 160;
    localparam logic [7:0] ECHO_BASE       = 8'hE0;
    localparam logic [7:0] ECHO_MASK       = 8'hDF;

endpackage

// File: rtl/lr35902_oam_dma.sv
// rtl/lr35902_oam_dma.sv - OAM DMA register 0xFF46 and 160-byte copy sequencer
// Optional echo-RAM source folding: LR35902_OAM_DMA_ECHO_FOLD_EN
module lr35902_oam_dma
    import lr35902_pkg::*;
#(
    parameter int unsigned STARTUP_CYCLES  = 4,
    parameter int unsigned CYCLES_PER_BYTE = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [7:0]  din,
    input  logic        write,
    output logic [7:0]  dout,
    output logic        busy,
    output logic        active,
    output logic [15:0] adr_rd,
    output logic        rd,
    input  logic [7:0]  data_in,
    output logic [7:0]  adr_wr,
    output logic        wr,
    output logic [7:0]  data_out
);

    localparam logic [3:0] START_CNT  = 4'(STARTUP_CYCLES);
    localparam logic [3:0] LAST_PHASE = 4'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0] LAST_IDX   = 8'(OAM_DMA_LEN - 1);
    localparam bit         DIRECT     = (STARTUP_CYCLES == 0);

    oam_dma_state_e state, state_nx;
    logic [7:0] src_hi, src_nx, src_eff;
    logic [7:0] idx, idx_nx;
    logic [3:0] phase, phase_nx;
    logic [3:0] cnt, cnt_nx;
    logic       active_nx;

    assign dout = src_hi;

    always_comb begin
`ifdef LR35902_OAM_DMA_ECHO_FOLD_EN
        src_eff = (src_nx >= ECHO_BASE) ? (src_nx & ECHO_MASK) : src_nx;
`else
        src_eff = src_nx;
`endif
    end

    // A register write wins over everything; active is only touched on entry
    // to XFER or return to IDLE so a restart keeps OAM locked.
    always_comb begin
        state_nx  = state;
        src_nx    = src_hi;
        idx_nx    = idx;
        phase_nx  = phase;
        cnt_nx    = cnt;
        active_nx = active;
        if (write) begin
            src_nx   = din;
            idx_nx   = 8'd0;
            phase_nx = 4'd0;
            cnt_nx   = START_CNT;
            if (DIRECT) begin
                state_nx  = XFER;
                active_nx = 1'b1;
            end else begin
                state_nx = START;
            end
        end else begin
            case (state)
                START: begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state_nx  = XFER;
                        active_nx = 1'b1;
                    end
                end
                XFER: begin
                    if (phase == LAST_PHASE) begin
                        phase_nx = 4'd0;
                        if (idx == LAST_IDX) begin
                            state_nx  = IDLE;
                            active_nx = 1'b0;
                        end else begin
                            idx_nx = idx + 8'd1;
                        end
                    end else begin
                        phase_nx = phase + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and addresses are registered from next-state values so they
    // line up with the cycle the sequencer is in.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            src_hi   <= 8'h00;
            idx      <= 8'd0;
            phase    <= 4'd0;
            cnt      <= 4'd0;
            busy     <= 1'b0;
            active   <= 1'b0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            adr_rd   <= 16'h0000;
            adr_wr   <= 8'h00;
            data_out <= 8'h00;
        end else begin
            state    <= state_nx;
            src_hi   <= src_nx;
            idx      <= idx_nx;
            phase    <= phase_nx;
            cnt      <= cnt_nx;
            busy     <= (state_nx != IDLE);
            active   <= active_nx;
            rd       <= (state_nx == XFER) && (phase_nx == 4'd0);
            wr       <= (state_nx == XFER) && (phase_nx == LAST_PHASE);
            adr_rd   <= {src_eff, idx_nx};
            adr_wr   <= idx_nx;
            if (rd) begin
                data_out <= data_in;
            end
        end
    end

endmodule

// File: doc/lr35902_oam_dma.md
Name: lr35902_oam_dma

Overview:
- OAM DMA engine for the LR35902 system: I/O register at 0xFF46 plus a sequencer that copies 160 bytes from {src_hi, 0x00..0x9F} to OAM 0x00..0x9F.
- Sits directly upstream of the DMA memory map, VRAM/external-bus muxing and OAM write port in the top level.
- Drives the dma_active, adr_dma_rd, rd_dma, adr_dma_wr, wr_dma and data_dma_out nets, replacing the current dma_active=0 tie-off.

Parameters:
- STARTUP_CYCLES, 4: clk cycles between the register write and the first source read; allowed range 0..15.
- CYCLES_PER_BYTE, 4: clk cycles per copied byte; allowed range 2..15.

Ports:
- clk  in  1  system clock (gbclk domain)
- n_reset  in  1  asynchronous active-low reset
- din  in  8  CPU write data for 0xFF46
- write  in  1  CPU write strobe, already qualified with cs_io_dma
- dout  out  8  0xFF46 readback value
- busy  out  1  startup delay or transfer in progress
- active  out  1  transfer phase; OAM owned by DMA, CPU OAM access blocked
- adr_rd  out  16  source address
- rd  out  1  source read strobe
- data_in  in  8  source data from the DMA read mux, valid in the same cycle as rd
- adr_wr  out  8  OAM destination index
- wr  out  1  OAM write strobe
- data_out  out  8  byte written to OAM

Behaviour:
- Reset (asynchronous, n_reset=0), all outputs and state cleared:
  - state=IDLE, src_hi=0x00, dout=0x00, idx=0, phase=0
  - busy=active=rd=wr=0, adr_rd=0x0000, adr_wr=0x00, data_out=0x00
- Reset mid-transfer aborts immediately. No further rd/wr until the next register write.
- Register write (write=1 at an edge), from any state:
  - src_hi<=din; dout<=din
  - restart counter<=STARTUP_CYCLES; idx<=0; phase<=0
  - state<=START, or XFER directly when STARTUP_CYCLES=0
- States:
  - IDLE: busy=0, active=0.
  - START: busy=1. active keeps its previous value, so a restart during XFER keeps OAM locked. No rd/wr is issued during START, including on a restart. The counter decrements each cycle; at 1 the state goes to XFER next edge.
  - XFER: busy=1, active=1. phase counts 0..CYCLES_PER_BYTE-1, then wraps.
- Per-byte timing in XFER:
  - phase 0: rd=1, adr_rd={src_hi', idx}. data_in is captured into data_out at the edge ending phase 0.
  - phase CYCLES_PER_BYTE-1: wr=1, adr_wr=idx, data_out=captured byte.
  - At phase wrap, idx increments. After the write with idx=159 (0x9F), state<=IDLE, so active/busy fall the next cycle.
  - rd and wr are never asserted in the same cycle.
- Total busy span after a write: STARTUP_CYCLES + 160*CYCLES_PER_BYTE cycles; 644 with defaults.
- idx width is 8 bits and never exceeds 0x9F.
- src_hi' = src_hi, unless folded by the optional feature.
- A write landing on the same edge as the final OAM write: the final write still occurs, then the restart takes effect.
- dout always returns the last written value, regardless of busy.

Optional Feature:
- Macro: LR35902_OAM_DMA_ECHO_FOLD_EN
- Defined: src_hi in 0xE0..0xFF gives src_hi' = src_hi & 0xDF, mirroring echo RAM onto 0xC0..0xDF. dout still returns the unfolded value.
- Undefined: src_hi'=src_hi unconditionally; the downstream memory map decodes the address.

Decomposition:
- Shared package lr35902_pkg gets:
  - state enum {IDLE, START, XFER}
  - OAM_DMA_REG_ADR=8'h46
  - OAM_DMA_LEN=160
  - ECHO_BASE=8'hE0, ECHO_MASK=8'hDF
- No sub-module: the counter/sequencer is small enough to stay flat in one module.

Test Plan:
- Write din=0xC1 with defaults -> busy for 644 cycles. First rd occurs 4 cycles after the write, at adr_rd=0xC100. Writes go to adr_wr 0x00..0x9F in order with data matching the source pattern. Last rd is at 0xC19F. Exactly 160 wr pulses. dout=0xC1.
- Write 0x80 during idx=0x50 -> active stays 1 across the restart. No rd/wr for 4 cycles. Next rd is at 0x8000. Exactly 160 wr pulses counted after the restart.
- Deassert n_reset mid-XFER (idx=0x20) -> all outputs 0 asynchronously, no further wr, dout=0x00 after release.
- With LR35902_OAM_DMA_ECHO_FOLD_EN, write 0xE3 -> reads are at 0xC300..0xC39F and dout=0xE3. Without the macro, reads are at 0xE300..0xE39F.
- CYCLES_PER_BYTE=2, STARTUP_CYCLES=0, write 0x00 -> first rd in the cycle after the write. rd and wr alternate every cycle. busy span is 320 cycles.
- Write exactly on the edge of the final wr (idx=0x9F) -> the final OAM write is observed, then the new transfer starts with idx=0.
